// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: switch-configuration loader for the 8x8 Benes network.
// Collects STAGES words (one per switch stage) into a shadow bank and then
// copies the whole bank into the active switch_set in a single cycle, so the
// network never sees a half-written configuration.
// Optional feature macro: BENES_CFG_PARITY_EN adds s_parity (even parity
// over s_data) and treats a parity mismatch as a frame error.
module benes_cfg_loader #(
  parameter int STAGES       = 5,
  parameter int SW_PER_STAGE = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [SW_PER_STAGE-1:0]                s_data,
  input  logic                                   s_last,
`ifdef BENES_CFG_PARITY_EN
  input  logic                                   s_parity,
`endif
  output logic [0:STAGES-1][SW_PER_STAGE-1:0]    switch_set,
  output logic                                   cfg_valid,
  output logic                                   commit_pulse,
  output logic                                   err_frame
);

  localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STAGES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]                              state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    rdy_q, rdy_d;
  logic                                    err_q, err_d;
  logic                                    cfgv_q;
  logic                                    pulse_q;
  logic [0:STAGES-1][SW_PER_STAGE-1:0]     shadow_q;
  logic [0:STAGES-1][SW_PER_STAGE-1:0]     active_q;
  logic                                    wr_en;
  logic                                    xfer;
  logic                                    word_bad;

`ifdef BENES_CFG_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_err(input logic [SW_PER_STAGE-1:0] d,
                                      input logic                    p);
    return ^{d, p};
  endfunction

  assign word_bad = parity_err(s_data, s_parity);
`else
  assign word_bad = 1'b0;
`endif

  // s_ready comes straight from a register, never from s_valid.
  assign xfer = s_valid && rdy_q;

  // Next-state logic: frame assembly, error detection and drain handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          if (word_bad) begin
            // Corrupt word: drop the frame, drain the rest unless it ends here.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = s_last ? ST_IDLE : ST_DRAIN;
          end else if (cnt_q == LAST_IDX) begin
            wr_en = 1'b1;
            cnt_d = '0;
            if (s_last) begin
              state_d = ST_COMMIT;
            end else begin
              // Frame too long: discard and swallow words up to the real end.
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_last) begin
            // Frame too short (includes a single-word frame from IDLE).
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            wr_en   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (xfer && s_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // The only bubble in the stream is the COMMIT cycle.
    rdy_d = (state_d != ST_COMMIT);
  end

  // Control state, sticky flags and the active bank (the active bank has a
  // defined all-bar value after reset, so it is reset with the control).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      cfgv_q   <= 1'b0;
      pulse_q  <= 1'b0;
      active_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      pulse_q <= (state_q == ST_COMMIT);
      if (state_q == ST_COMMIT) begin
        active_q <= shadow_q;
        cfgv_q   <= 1'b1;
      end
    end
  end

  // Shadow bank: pure datapath, every committed frame rewrites all entries,
  // so stale contents from a discarded frame can never reach the network.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_q[cnt_q] <= s_data;
    end
  end

  assign s_ready      = rdy_q;
  assign switch_set   = active_q;
  assign cfg_valid    = cfgv_q;
  assign commit_pulse = pulse_q;
  assign err_frame    = err_q;

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Bench for benes_cfg_loader: directed frames, expected commits queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_benes_cfg_loader;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [3:0]       s_data;
  logic             s_last;
`ifdef BENES_CFG_PARITY_EN
  logic             s_parity;
`endif
  logic [0:4][3:0]  switch_set;
  logic             cfg_valid;
  logic             commit_pulse;
  logic             err_frame;
  logic [19:0]      sw_flat;

  int total = 0;
  int bad   = 0;
  int n_pulse = 0;
  logic prev_pulse = 1'b0;
  logic [19:0] exp_q[$];

  benes_cfg_loader #(.STAGES(5), .SW_PER_STAGE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
`ifdef BENES_CFG_PARITY_EN
    .s_parity     (s_parity),
`endif
    .switch_set   (switch_set),
    .cfg_valid    (cfg_valid),
    .commit_pulse (commit_pulse),
    .err_frame    (err_frame)
  );

  assign sw_flat = switch_set;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance one clock; we always sit 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word, optionally after an idle gap; hold until accepted.
  task automatic send(input logic [3:0] d, input logic last, input logic par_flip, input int gap);
    logic acc;
    int   n;
    s_valid = 1'b0;
    step(gap);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
`ifdef BENES_CFG_PARITY_EN
    s_parity = (^d) ^ par_flip;
`else
    if (par_flip) s_data = d;
`endif
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = s_ready;
      step(1);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [19:0] f, input int max_gap);
    for (int i = 0; i < 5; i++) begin
      logic [19:0] tmp;
      tmp = f >> (4 * (4 - i));
      send(tmp[3:0], (i == 4), 1'b0, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  // Monitor: every commit pops the next expected configuration.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (commit_pulse) begin
        n_pulse++;
        if (prev_pulse) begin
          total++;
          bad++;
          $display("FAIL pulse_consecutive actual=1 required=0");
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit actual=%05h required=no_commit", sw_flat);
        end else begin
          e = exp_q.pop_front();
          chk("commit_cfg", 32'(sw_flat), 32'(e));
          chk("commit_cfg_valid", 32'(cfg_valid), 32'd1);
        end
      end
      prev_pulse = commit_pulse;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 4'h0;
    s_last  = 1'b0;
`ifdef BENES_CFG_PARITY_EN
    s_parity = 1'b0;
`endif
    step(3);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_switch_set", 32'(sw_flat), 0);
    chk("rst_cfg_valid", 32'(cfg_valid), 0);
    chk("rst_pulse", 32'(commit_pulse), 0);
    chk("rst_err", 32'(err_frame), 0);
    rst = 1'b0;
    step(1);
    chk("ready_after_rst", 32'(s_ready), 1);

    // Basic frame {1,2,4,8,F}.
    exp_q.push_back(20'h1248F);
    send_frame(20'h1248F, 0);
    chk("commit_ready_low", 32'(s_ready), 0);
    chk("pre_commit_cfg", 32'(sw_flat), 0);
    step(1);
    chk("commit_pulse_hi", 32'(commit_pulse), 1);
    chk("cfg_valid_hi", 32'(cfg_valid), 1);
    chk("cfg_f1", 32'(sw_flat), 32'h1248F);
    step(1);
    chk("commit_pulse_lo", 32'(commit_pulse), 0);

    // Early s_last on word 2.
    send(4'h9, 1'b0, 1'b0, 0);
    send(4'h9, 1'b0, 1'b0, 0);
    send(4'h9, 1'b1, 1'b0, 0);
    chk("early_last_err", 32'(err_frame), 1);
    chk("early_last_cfg", 32'(sw_flat), 32'h1248F);
    chk("early_last_ready", 32'(s_ready), 1);
    exp_q.push_back(20'h00000);
    send_frame(20'h00000, 0);
    step(2);
    chk("zero_frame_cfg", 32'(sw_flat), 0);

    // Two back-to-back frames with random valid gaps.
    p0 = n_pulse;
    exp_q.push_back(20'hA5A5A);
    exp_q.push_back(20'h3C3C3);
    send_frame(20'hA5A5A, 2);
    send_frame(20'h3C3C3, 2);
    step(4);
    chk("b2b_pulses", 32'(n_pulse - p0), 2);
    chk("b2b_cfg", 32'(sw_flat), 32'h3C3C3);

    // Reset in mid-frame after word 3.
    for (int i = 0; i < 4; i++) send(4'h7, 1'b0, 1'b0, 0);
    rst = 1'b1;
    step(1);
    chk("midrst_ready", 32'(s_ready), 0);
    chk("midrst_cfg", 32'(sw_flat), 0);
    chk("midrst_cfg_valid", 32'(cfg_valid), 0);
    chk("midrst_err", 32'(err_frame), 0);
    chk("midrst_pulse", 32'(commit_pulse), 0);
    rst = 1'b0;
    step(1);
    chk("midrst_ready_back", 32'(s_ready), 1);
    exp_q.push_back(20'h69690);
    send_frame(20'h69690, 0);
    step(2);
    chk("post_rst_cfg", 32'(sw_flat), 32'h69690);
    chk("post_rst_err", 32'(err_frame), 0);

    // Overlong frame: 7 words, s_last only on word 6.
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) send(4'h5, 1'b0, 1'b0, 0);
    chk("long_err_w3", 32'(err_frame), 0);
    send(4'h5, 1'b0, 1'b0, 0);
    chk("long_err_w4", 32'(err_frame), 1);
    send(4'h5, 1'b0, 1'b0, 0);
    chk("drain_ready", 32'(s_ready), 1);
    send(4'h5, 1'b1, 1'b0, 0);
    chk("drain_end_ready", 32'(s_ready), 1);
    step(3);
    chk("long_no_commit", 32'(n_pulse - p0), 0);
    chk("long_cfg", 32'(sw_flat), 32'h69690);

`ifdef BENES_CFG_PARITY_EN
    // Parity error on word 1 (0x3 with parity 1).
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    exp_q.push_back(20'h1248F);
    send_frame(20'h1248F, 0);
    step(2);
    p0 = n_pulse;
    send(4'h1, 1'b0, 1'b0, 0);
    chk("par_err_before", 32'(err_frame), 0);
    send(4'h3, 1'b0, 1'b1, 0);
    chk("par_err", 32'(err_frame), 1);
    send(4'h4, 1'b0, 1'b0, 0);
    send(4'h8, 1'b0, 1'b0, 0);
    send(4'hF, 1'b1, 1'b0, 0);
    step(3);
    chk("par_no_commit", 32'(n_pulse - p0), 0);
    chk("par_cfg", 32'(sw_flat), 32'h1248F);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
